// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared types and constants for the multi-cycle shift unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic [1:0] {
        SH_ARITH = 2'd0,
        SH_LOGIC = 2'd1,
        SH_ROT   = 2'd2,
        SH_RSVD  = 2'd3
    } shift_mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step
//  Description : Combinational single-bit shift/rotate step, either direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    input  logic             dir,
    input  shift_mode_t      mode,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in;
        if (dir == DIR_LEFT) begin
            // Arithmetic and logical left shifts are the same operation
            if (mode == SH_ROT) begin
                out = {in[WIDTH-2:0], in[WIDTH-1]};
            end else begin
                out = {in[WIDTH-2:0], 1'b0};
            end
        end else begin
            case (mode)
                SH_ARITH: out = {in[WIDTH-1], in[WIDTH-1:1]};
                SH_ROT:   out = {in[0], in[WIDTH-1:1]};
                default:  out = {1'b0, in[WIDTH-1:1]};
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multi_shift_unit
//  Description : Serial shifter, one bit per clock for a programmable amount,
//                with start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] din,
    input  logic [AMT_W-1:0]        amount,
    input  logic                    dir,
    input  logic [1:0]              mode,
    output logic signed [WIDTH-1:0] out,
    output logic                    busy,
    output logic                    done
);

    shift_state_t      r_state;
    logic [WIDTH-1:0]  r_out;
    logic [AMT_W-1:0]  r_count;
    logic              r_dir;
    shift_mode_t       r_mode;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  w_step;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .in   (r_out),
        .dir  (r_dir),
        .mode (r_mode),
        .out  (w_step)
    );

    // busy/done are registered alongside the state so they track it exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_mode  <= SH_ARITH;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_out   <= din;
                        r_count <= amount;
                        r_dir   <= dir;
                        r_mode  <= shift_mode_t'(mode);
                        r_busy  <= 1'b1;
                        if (amount != '0) begin
                            r_state <= S_SHIFT;
                            r_done  <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_out   <= w_step;
                    r_count <= r_count - AMT_W'(1);
                    if (r_count == AMT_W'(1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_multi_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_shift_unit
//  Description : Scoreboard-based self-checking bench for multi_shift_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_shift_unit;

    localparam int WIDTH = 16;
    localparam int AMT_W = 5;

    typedef struct {
        logic [WIDTH-1:0] res;
        int               lat;
        string            name;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic signed [WIDTH-1:0] din = '0;
    logic [AMT_W-1:0]        amount = '0;
    logic                    dir = 1'b0;
    logic [1:0]              mode = 2'd0;
    logic signed [WIDTH-1:0] out;
    logic                    busy;
    logic                    done;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    multi_shift_unit #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .din    (din),
        .amount (amount),
        .dir    (dir),
        .mode   (mode),
        .out    (out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Reference: apply the single-bit step rule n times
    function automatic logic [WIDTH-1:0] model(logic [WIDTH-1:0] d, int n, logic dr, logic [1:0] m);
        logic [WIDTH-1:0] v;
        v = d;
        for (int i = 0; i < n; i++) begin
            if (dr) v = (m == 2'd2) ? {v[WIDTH-2:0], v[WIDTH-1]} : {v[WIDTH-2:0], 1'b0};
            else if (m == 2'd0) v = {v[WIDTH-1], v[WIDTH-1:1]};
            else if (m == 2'd2) v = {v[0], v[WIDTH-1:1]};
            else v = {1'b0, v[WIDTH-1:1]};
        end
        return v;
    endfunction

    task automatic drive_start(input logic [WIDTH-1:0] d, input int n, input logic dr,
                               input logic [1:0] m, input logic [WIDTH-1:0] res, input string name);
        exp_t e;
        @(negedge clk);
        din    = d;
        amount = AMT_W'(n);
        dir    = dr;
        mode   = m;
        start  = 1'b1;
        e.res  = res;
        e.lat  = n + 1;
        e.name = name;
        sb.push_back(e);
    endtask

    // Waits for done, scrambling the inputs to prove they are not re-sampled
    task automatic wait_done();
        int   cyc = 0;
        int   bcyc = 0;
        bit   seen = 0;
        exp_t e;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            start  = 1'b0;
            din    = WIDTH'($urandom);
            amount = AMT_W'($urandom);
            dir    = 1'($urandom);
            mode   = 2'($urandom);
            cyc++;
            if (busy) bcyc++;
            if (done) seen = 1;
        end
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout: no done within %0d cycles, required latency %0d", e.name, cyc, e.lat);
        end else begin
            if (out !== e.res) begin
                failures++;
                $display("FAIL %s result: actual %h required %h", e.name, out, e.res);
            end
            checks++;
            if (cyc != e.lat) begin
                failures++;
                $display("FAIL %s latency: actual %0d required %0d", e.name, cyc, e.lat);
            end
            checks++;
            if (bcyc != e.lat) begin
                failures++;
                $display("FAIL %s busy_cycles: actual %0d required %0d", e.name, bcyc, e.lat);
            end
        end
    endtask

    task automatic check_idle(input logic [WIDTH-1:0] exp_out, input string name);
        checks++;
        if (out !== exp_out || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: actual out=%h busy=%b done=%b required out=%h busy=0 done=0",
                     name, out, busy, done, exp_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        din   = 16'hFFFF;
        repeat (3) @(negedge clk);
        check_idle(16'h0000, "reset");
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(16'h0000, "post_reset");
    endtask

    task automatic test_basic();
        drive_start(16'h8000, 3, 1'b0, 2'd0, 16'hF000, "right_arith");
        wait_done();
        @(negedge clk);
        check_idle(16'hF000, "after_done");
        drive_start(16'h8000, 3, 1'b0, 2'd1, 16'h1000, "right_logic");
        wait_done();
        drive_start(16'h1234, 4, 1'b1, 2'd2, 16'h2341, "left_rot");
        wait_done();
        drive_start(16'h00F1, 2, 1'b1, 2'd0, 16'h03C4, "left_arith");
        wait_done();
        drive_start(16'h8001, 1, 1'b0, 2'd3, 16'h4000, "right_rsvd");
        wait_done();
    endtask

    task automatic test_boundaries();
        drive_start(16'hABCD, 0, 1'b0, 2'd0, 16'hABCD, "amount0");
        wait_done();
        drive_start(16'hFFFF, 16, 1'b0, 2'd1, 16'h0000, "logic_r16");
        wait_done();
        drive_start(16'h8001, 16, 1'b0, 2'd0, 16'hFFFF, "arith_r16");
        wait_done();
        drive_start(16'h1234, 16, 1'b0, 2'd2, 16'h1234, "rot_r16");
        wait_done();
        drive_start(16'h1234, 16, 1'b1, 2'd2, 16'h1234, "rot_l16");
        wait_done();
        drive_start(16'hFFFF, 16, 1'b1, 2'd1, 16'h0000, "logic_l16");
        wait_done();
    endtask

    task automatic test_ignore_start();
        drive_start(16'h8000, 3, 1'b0, 2'd0, 16'hF000, "ignore_first");
        @(negedge clk);            // in SHIFT: competing start
        din = 16'h5555; amount = '0; dir = 1'b1; mode = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);            // expected DONE cycle
        checks++;
        if (done !== 1'b1 || out !== 16'hF000) begin
            failures++;
            $display("FAIL ignore_done: actual done=%b out=%h required done=1 out=f000", done, out);
        end
        if (sb.size() > 0) void'(sb.pop_front());
        din = 16'h1111; amount = 5'd1; start = 1'b1;   // start during DONE
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_idle(16'hF000, "ignore_hold");
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        bit spurious = 0;
        drive_start(16'h1234, 10, 1'b1, 2'd1, 16'h0000, "abort");
        void'(sb.pop_back());
        repeat (4) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(16'h0000, "abort_reset");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) spurious = 1;
        end
        checks++;
        if (spurious) begin
            failures++;
            $display("FAIL abort_no_done: actual activity after abort, required none");
        end
        drive_start(16'h00FF, 4, 1'b1, 2'd2, 16'h0FF0, "after_abort");
        wait_done();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [WIDTH-1:0] d;
            int               n;
            logic             dr;
            logic [1:0]       m;
            d  = WIDTH'($urandom);
            n  = $urandom_range(0, 16);
            dr = 1'($urandom);
            m  = 2'($urandom);
            drive_start(d, n, dr, m, model(d, n, dr, m), $sformatf("b2b_%0d", i));
            wait_done();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
